// File: rtl/computation_core.sv
// -----------------------------------------------------------------------------
// computation_core
//
// Arithmetic core of the LeNet5 accelerator. A 5x5 convolution
// multiply-accumulate stage (UUT1) feeds a 2x2 max-pooling stage (UUT2).
//
// Every rising clock edge with reset released consumes one signed
// data/weight pair. There is no valid/enable qualifier.
//   - Every kernel_len products form one convolution result.
//   - Every pool_len convolution results are reduced to their signed maximum.
//     That maximum is presented on max_number together with a one-cycle
//     flag_store strobe.
//
// Ports:
//   clk         in   1            system clock, rising edge
//   reset       in   1            asynchronous, active-low reset
//   data        in   bitwidth     signed activation sample
//   weight      in   bitwidth     signed kernel weight
//   max_number  out  2*bitwidth   signed max of the last pool_len results
//   flag_store  out  1            one-cycle strobe: max_number just updated
//
// Handshake: none. The core is a free-running pipeline. A result is valid
// exactly in the cycle its strobe (flag_over / flag_start / flag_store) is
// high. The result value itself is held until it is next overwritten.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// computation_core_mac
//
// Multiply-accumulate over fixed windows of kernel_len pairs. Windows are
// aligned to reset release.
//
// Ports:
//   clk, reset  clock / async active-low reset
//   data        in   bitwidth    signed sample
//   weight      in   bitwidth    signed weight
//   c           out  2*bitwidth  sum of the last complete window (held)
//   flag_over   out  1           high for one cycle after each window closes
// -----------------------------------------------------------------------------
module computation_core_mac #(
    parameter int bitwidth   = 17,
    parameter int kernel_len = 25
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [bitwidth-1:0]   data,
    input  logic signed [bitwidth-1:0]   weight,
    output logic signed [2*bitwidth-1:0] c,
    output logic                         flag_over
);

    localparam int RW = 2 * bitwidth;
    localparam int CW = (kernel_len > 1) ? $clog2(kernel_len) : 1;

    logic signed [RW-1:0] data_ext;
    logic signed [RW-1:0] weight_ext;
    logic signed [RW-1:0] product;
    logic signed [RW-1:0] sum;

    logic signed [RW-1:0] acc_q, acc_d;
    logic signed [RW-1:0] c_q, c_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 flag_over_q, flag_over_d;

    // Sign-extend both operands to the result width. The product of two
    // bitwidth-bit signed values always fits in 2*bitwidth bits, so this
    // gives the exact product.
    assign data_ext   = $signed({{bitwidth{data[bitwidth-1]}}, data});
    assign weight_ext = $signed({{bitwidth{weight[bitwidth-1]}}, weight});
    assign product    = data_ext * weight_ext;

    // Wraps modulo 2^RW on overflow.
    assign sum = acc_q + product;

    always_comb begin
        acc_d       = sum;
        count_d     = count_q + CW'(1);
        c_d         = c_q;
        flag_over_d = 1'b0;
        if (count_q == CW'(kernel_len - 1)) begin
            // Last pair of the window. Publish the total and start a fresh window.
            acc_d       = '0;
            count_d     = '0;
            c_d         = sum;
            flag_over_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            count_q     <= '0;
            c_q         <= '0;
            flag_over_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            c_q         <= c_d;
            flag_over_q <= flag_over_d;
        end
    end

    assign c         = c_q;
    assign flag_over = flag_over_q;

endmodule

// -----------------------------------------------------------------------------
// computation_core_pool
//
// Collects convolution results into slots a, b, c, d in arrival order. Once
// all four slots are filled, it publishes their signed maximum.
//
// Ports:
//   clk, reset  clock / async active-low reset
//   c_in        in   2*bitwidth  convolution result from the MAC stage
//   flag_over   in   1           c_in holds a fresh result this cycle
//   max_number  out  2*bitwidth  signed max of the four slots (held)
//   flag_store  out  1           high for one cycle when max_number updates
// -----------------------------------------------------------------------------
module computation_core_pool #(
    parameter int bitwidth = 17,
    parameter int pool_len = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [2*bitwidth-1:0] c_in,
    input  logic                         flag_over,
    output logic signed [2*bitwidth-1:0] max_number,
    output logic                         flag_store
);

    localparam int RW = 2 * bitwidth;
    localparam int IW = (pool_len > 1) ? $clog2(pool_len) : 1;

    logic signed [RW-1:0] data_in_q, data_in_d;
    logic signed [RW-1:0] a_q, a_d;
    logic signed [RW-1:0] b_q, b_d;
    logic signed [RW-1:0] c_q, c_d;
    logic signed [RW-1:0] d_q, d_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 flag_start_q, flag_start_d;
    logic signed [RW-1:0] max_q, max_d;
    logic                 flag_store_q, flag_store_d;

    logic signed [RW-1:0] max_ab, max_cd, max_all;

    // Signed two-level compare tree. On a tie, either operand gives the same value.
    assign max_ab  = (a_q > b_q) ? a_q : b_q;
    assign max_cd  = (c_q > d_q) ? c_q : d_q;
    assign max_all = (max_ab > max_cd) ? max_ab : max_cd;

    always_comb begin
        data_in_d    = data_in_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        d_d          = d_q;
        idx_d        = idx_q;
        flag_start_d = 1'b0;
        max_d        = max_q;
        flag_store_d = 1'b0;

        if (flag_over) begin
            data_in_d = c_in;
            case (idx_q)
                IW'(0):  a_d = c_in;
                IW'(1):  b_d = c_in;
                IW'(2):  c_d = c_in;
                default: d_d = c_in;
            endcase
            if (idx_q == IW'(pool_len - 1)) begin
                idx_d        = '0;
                flag_start_d = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end

        // flag_over is at least 25 cycles apart. So the slots are stable
        // while flag_start is high, and the max sees the full set.
        if (flag_start_q) begin
            max_d        = max_all;
            flag_store_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_in_q    <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            d_q          <= '0;
            idx_q        <= '0;
            flag_start_q <= 1'b0;
            max_q        <= '0;
            flag_store_q <= 1'b0;
        end else begin
            data_in_q    <= data_in_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            d_q          <= d_d;
            idx_q        <= idx_d;
            flag_start_q <= flag_start_d;
            max_q        <= max_d;
            flag_store_q <= flag_store_d;
        end
    end

    assign max_number = max_q;
    assign flag_store = flag_store_q;

endmodule

// -----------------------------------------------------------------------------
// computation_core (top)
// -----------------------------------------------------------------------------
module computation_core #(
    parameter int bitwidth   = 17,
    parameter int kernel_len = 25,
    parameter int pool_len   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [bitwidth-1:0]   data,
    input  logic signed [bitwidth-1:0]   weight,
    output logic signed [2*bitwidth-1:0] max_number,
    output logic                         flag_store
);

    logic signed [2*bitwidth-1:0] conv_result;
    logic                         conv_valid;

    computation_core_mac #(
        .bitwidth   (bitwidth),
        .kernel_len (kernel_len)
    ) UUT1 (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .weight    (weight),
        .c         (conv_result),
        .flag_over (conv_valid)
    );

    computation_core_pool #(
        .bitwidth (bitwidth),
        .pool_len (pool_len)
    ) UUT2 (
        .clk        (clk),
        .reset      (reset),
        .c_in       (conv_result),
        .flag_over  (conv_valid),
        .max_number (max_number),
        .flag_store (flag_store)
    );

endmodule

// File: tb/tb_computation_core.sv
module tb_computation_core;

    logic               clk;
    logic               reset;
    logic signed [16:0] data;
    logic signed [16:0] weight;
    logic signed [33:0] max_number;
    logic               flag_store;

    int checks   = 0;
    int failures = 0;

    computation_core dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .weight     (weight),
        .max_number (max_number),
        .flag_store (flag_store)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Hold reset low for a few cycles and check the cleared state. Then
    // release just after a rising edge, so the next edge is edge 1.
    task automatic apply_reset(input string name);
        @(negedge clk);
        reset  = 1'b0;
        data   = '0;
        weight = '0;
        repeat (2) @(negedge clk);
        check({name, ":rst_max"},        max_number, 34'd0);
        check({name, ":rst_store"},      34'(flag_store), 34'd0);
        check({name, ":rst_c"},          dut.UUT1.c, 34'd0);
        check({name, ":rst_flag_over"},  34'(dut.UUT1.flag_over), 34'd0);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Drive one pair; it is consumed on the following rising edge. Return
    // 1 time unit after that edge, so the caller samples fresh outputs.
    task automatic step(input int d, input int w);
        @(negedge clk);
        data   = 17'(d);
        weight = 17'(w);
        @(posedge clk);
        #1;
    endtask

    // Feed four windows of constant pairs, starting at edge 1. Then keep
    // feeding the last pair through edge 202. From edge 101 on, every window
    // uses pair 3, so the second pooled output equals exp_c[3].
    task automatic run_pool(input string name, input int d[4], input int w[4],
                            input logic [33:0] exp_c[4], input logic [33:0] exp_max);
        int stray_store = 0;
        int stray_over  = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 25; i++) begin
                step(d[k], w[k]);
                if (flag_store) stray_store++;
                if (i < 24 && dut.UUT1.flag_over) stray_over++;
            end
            check($sformatf("%s:c%0d", name, k), dut.UUT1.c, exp_c[k]);
            check($sformatf("%s:flag_over%0d", name, k), 34'(dut.UUT1.flag_over), 34'd1);
        end
        for (int e = 101; e <= 202; e++) begin
            step(d[3], w[3]);
            if (e == 101) begin
                check({name, ":e101_store"},   34'(flag_store), 34'd0);
                check({name, ":e101_start"},   34'(dut.UUT2.flag_start_q), 34'd1);
                check({name, ":slot_a"},       dut.UUT2.a_q, exp_c[0]);
                check({name, ":slot_b"},       dut.UUT2.b_q, exp_c[1]);
                check({name, ":slot_c"},       dut.UUT2.c_q, exp_c[2]);
                check({name, ":slot_d"},       dut.UUT2.d_q, exp_c[3]);
                check({name, ":data_in"},      dut.UUT2.data_in_q, exp_c[3]);
            end else if (e == 102) begin
                check({name, ":e102_max"},     max_number, exp_max);
                check({name, ":e102_store"},   34'(flag_store), 34'd1);
            end else if (e == 103) begin
                check({name, ":e103_store"},   34'(flag_store), 34'd0);
                check({name, ":e103_hold"},    max_number, exp_max);
            end else if (e == 202) begin
                check({name, ":e202_store"},   34'(flag_store), 34'd1);
                check({name, ":e202_max"},     max_number, exp_c[3]);
            end else if (flag_store) begin
                stray_store++;
            end
        end
        check({name, ":stray_store"}, 34'(stray_store), 34'd0);
        check({name, ":stray_over"},  34'(stray_over), 34'd0);
    endtask

    initial begin
        int d[4];
        int w[4];
        logic [33:0] ec[4];

        reset  = 1'b0;
        data   = '0;
        weight = '0;

        // constant 1*2 -> 50 per window
        apply_reset("const12");
        d = '{1, 1, 1, 1};  w = '{2, 2, 2, 2};
        ec = '{34'd50, 34'd50, 34'd50, 34'd50};
        run_pool("const12", d, w, ec, 34'd50);

        // constant 2*3 -> 150
        apply_reset("const23");
        d = '{2, 2, 2, 2};  w = '{3, 3, 3, 3};
        ec = '{34'd150, 34'd150, 34'd150, 34'd150};
        run_pool("const23", d, w, ec, 34'd150);

        // mixed windows 50, 100, 150, 125 -> max 150 (in slot c)
        apply_reset("mixed");
        d = '{1, 4, 2, 1};  w = '{2, 1, 3, 5};
        ec = '{34'd50, 34'd100, 34'd150, 34'd125};
        run_pool("mixed", d, w, ec, 34'd150);

        // all negative, constant -3*4 -> -300
        apply_reset("neg_const");
        d = '{-3, -3, -3, -3};  w = '{4, 4, 4, 4};
        ec = '{-34'sd300, -34'sd300, -34'sd300, -34'sd300};
        run_pool("neg_const", d, w, ec, -34'sd300);

        // negative set {-300, -50, -1000, -25} -> -25
        apply_reset("neg_set");
        d = '{-3, -2, -8, -1};  w = '{4, 1, 5, 1};
        ec = '{-34'sd300, -34'sd50, -34'sd1000, -34'sd25};
        run_pool("neg_set", d, w, ec, -34'sd25);

        // mixed sign set {-300, 50, -1000, -25} -> 50 (positive beats negative)
        apply_reset("sign_mix");
        d = '{-3, 1, -8, -1};  w = '{4, 2, 5, 1};
        ec = '{-34'sd300, 34'd50, -34'sd1000, -34'sd25};
        run_pool("sign_mix", d, w, ec, 34'd50);

        // overflow: (-65536)^2 = 2^32; 25*2^32 mod 2^34 = 2^32
        apply_reset("overflow");
        d = '{-65536, -65536, -65536, -65536};  w = '{-65536, -65536, -65536, -65536};
        ec = '{34'h1_0000_0000, 34'h1_0000_0000, 34'h1_0000_0000, 34'h1_0000_0000};
        run_pool("overflow", d, w, ec, 34'h1_0000_0000);

        // reset mid-operation: after 60 edges, slot a holds 50 and the
        // accumulator is partially filled. Both must be discarded.
        apply_reset("midrst");
        repeat (60) step(1, 2);
        check("midrst:pre_slot_a", dut.UUT2.a_q, 34'd50);
        #2 reset = 1'b0;
        #1;
        check("midrst:acc_clear",   dut.UUT1.acc_q, 34'd0);
        check("midrst:count_clear", 34'(dut.UUT1.count_q), 34'd0);
        check("midrst:slot_clear",  dut.UUT2.a_q, 34'd0);
        check("midrst:idx_clear",   34'(dut.UUT2.idx_q), 34'd0);
        check("midrst:c_clear",     dut.UUT1.c, 34'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        d = '{1, 1, 1, 1};  w = '{1, 1, 1, 1};
        ec = '{34'd25, 34'd25, 34'd25, 34'd25};
        run_pool("midrst", d, w, ec, 34'd25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/computation_core.md
Name: computation_core

Overview:
- Arithmetic core of the LeNet5 accelerator: a 5x5 convolution multiply-accumulate stage feeding a 2x2 max-pooling stage.
- Each cycle one signed data/weight pair is multiplied and accumulated.
- Every 25 products form one convolution result. Every 4 convolution results are reduced to their maximum, which is presented as max_number with a one-cycle flag_store strobe.
- Sub-blocks: MAC stage (instance UUT1) and pooling stage (instance UUT2).

Parameters:
- bitwidth, 17, width of signed data and weight; all results are 2*bitwidth bits.
- kernel_len, 25, products per convolution result (5x5).
- pool_len, 4, convolution results per pooled output (2x2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- data  input  bitwidth  signed activation sample.
- weight  input  bitwidth  signed kernel weight.
- max_number  output  2*bitwidth  signed max of last 4 convolution results (registered).
- flag_store  output  1  one-cycle strobe: max_number just updated, store it.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low (reset=0 clears; reset=1 runs).
- While reset=0, all registers are 0: accumulator, count, UUT1.c, UUT1.flag_over, UUT2.data_in, a, b, c, d, slot index, UUT2.flag_start, max_number, flag_store.
- MAC stage (UUT1):
  - product = data*weight, full signed 2*bitwidth.
  - Accumulator and c are signed 2*bitwidth and wrap modulo 2^(2*bitwidth) on overflow.
  - Every rising edge with reset=1 consumes the current data/weight pair; there is no valid/enable input.
  - count 0..kernel_len-1. When count<24: acc<=acc+product, count<=count+1, flag_over<=0.
  - When count==24: c<=acc+product, acc<=0, count<=0, flag_over<=1.
  - Result: flag_over is high for exactly one cycle after every 25th consumed pair, and c holds the sum of those 25 products until the next result.
- Pooling stage (UUT2):
  - On an edge with flag_over=1: data_in<=UUT1.c, which equals the new c visible that cycle.
  - In the same edge, UUT1.c is written into slot a, b, c, then d in order (slot index 0..3) and the index increments.
  - When slot d is written: index wraps to 0 and flag_start<=1 on that edge. Otherwise flag_start<=0.
  - On an edge with flag_start=1: max_number<=signed max(a,b,c,d) and flag_store<=1. Otherwise flag_store<=0.
  - max_number holds its value between updates. Ties resolve to the same value.
- Latency from reset release:
  - First flag_over after edge 25.
  - 4th flag_over after edge 100.
  - flag_start high after edge 101.
  - max_number valid and flag_store high after edge 102.
  - Thereafter one pooled output every 100 cycles.
- flag_over cannot coincide with flag_start; the minimum flag_over spacing of 25 cycles guarantees this.
- Windows are fixed 25-cycle blocks aligned to reset release. A data/weight change mid-window mixes old and new products in that result.
- Reset mid-operation: immediate clear of all state. Partial windows and partial pool sets are discarded; counting restarts at edge 1 after release.
- Comparison is signed: negative results never beat positive ones.

Test Plan:
- Reset then data=1, weight=2 constant: UUT1.c=50 with flag_over pulses every 25 cycles. After edge 102: max_number=50, flag_store high for 1 cycle, repeating every 100 cycles.
- data=2, weight=3 constant: each c=150, max_number=150.
- Per-window sequence (data,weight) = (1,2), (4,1), (2,3), (1,5), each held 25 cycles: a=50, b=100, c=150, d=125; max_number=150.
- Signed: data=-3, weight=4 constant -> c=-300, max_number=-300. Window set {-300, -50, -1000, -25} -> max_number=-25.
- Overflow: data=-65536, weight=-65536 constant (product 2^32) -> c wraps to (25*2^32) mod 2^34 = 2^32.
- Reset low at edge 60, released, then data=1, weight=1: flag_over 25 edges after release, c=25. Old partial sum and slot a are discarded; first flag_store 102 edges after release, max_number=25.
